knn_reset_sequencer: RTL and testbench

Avalon-MM slave on the Nios II SOPC that replaces software bit-banging of the KNN core's reset line with a hardware-timed sequence. One "go" write holds the KNN core in reset for a programmable number of cycles, waits a fixed settle time, and issues a one-cycle start pulse. It then waits for the core's done signal, with an optional timeout, and reports completion through a status register and an interrupt.

---
 rtl/knn_seq_pkg.sv | 36 +++
 rtl/knn_seq_down_counter.sv | 28 ++
 rtl/knn_reset_sequencer.sv | 179 +++++++++++++++++
 tb/tb_knn_reset_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/knn_seq_pkg.sv
// Shared definitions for the KNN reset sequencer: state codes,
// register map, CTRL/STATUS bit positions and reset values.
package knn_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_SETTLE = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4
  } state_t;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_RLEN   = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_TMO    = 2'd3;

  localparam int CTRL_GO     = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STS_BUSY    = 0;
  localparam int STS_DONE    = 1;
  localparam int STS_TMO     = 2;
  localparam int STS_ABORTED = 3;
  localparam int STS_STATE   = 4;

  localparam int RLEN_RST = 16;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/knn_seq_down_counter.sv
// Loadable down counter shared by the RST, SETTLE and WAIT phases.
// Ports: clk, reset, load/load_val, dec, at_one (count == 1).
module knn_seq_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         at_one
);

  logic [W-1:0] cnt;

  // Saturates at 0 so a zero load (timeout disabled) never reaches 1.
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign at_one = (cnt == W'(1));

endmodule

// File: rtl/knn_reset_sequencer.sv
// Avalon-MM slave that times the KNN core reset/start sequence.
// Ports: Avalon slave (address/chipselect/write_n/writedata/readdata),
// knn_reset/knn_start/knn_done to the core, irq to the CPU.
module knn_reset_sequencer
  import knn_seq_pkg::*;
#(
  parameter int RST_LEN_W     = 8,
  parameter int TMO_W         = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        knn_reset,
  output logic        knn_start,
  input  logic        knn_done,
  output logic        irq
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int CW = max3(RST_LEN_W, TMO_W, SW);

  state_t state, state_next;

  logic [RST_LEN_W-1:0] rst_len;
  logic [RST_LEN_W-1:0] len_eff;
  logic [TMO_W-1:0]     timeout;
  logic [TMO_W-1:0]     tmo_snap;
  logic                 irq_en;
  logic                 done_f, tmo_f, abort_f;

  logic wr, wr_ctrl, wr_status;
  logic go, abort;
  logic cnt_load, cnt_dec, at_one;
  logic [CW-1:0] cnt_val;
  logic set_done, set_tmo, set_abort;
  logic [31:0] rd_mux;
  logic unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr && address == A_CTRL;
  assign wr_status = wr && address == A_STATUS;
  assign abort     = wr_ctrl & writedata[CTRL_ABORT];
  assign go        = wr_ctrl & writedata[CTRL_GO] & ~writedata[CTRL_ABORT];
  assign len_eff   = (rst_len == '0) ? RST_LEN_W'(1) : rst_len;
  assign unused_wd = ^writedata;

  knn_seq_down_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .at_one   (at_one)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_dec    = 1'b0;
    set_done   = 1'b0;
    set_tmo    = 1'b0;
    set_abort  = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          cnt_load   = 1'b1;
          cnt_val    = CW'(len_eff);
          state_next = S_RST;
        end
      end
      S_RST: begin
        if (at_one) begin
          cnt_load   = 1'b1;
          cnt_val    = CW'(SETTLE_CYCLES);
          state_next = S_SETTLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_SETTLE: begin
        if (at_one)
          state_next = S_START;
        else
          cnt_dec = 1'b1;
      end
      S_START: begin
        cnt_load   = 1'b1;
        cnt_val    = CW'(tmo_snap);
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (knn_done) begin
          set_done   = 1'b1;
          state_next = S_IDLE;
        end else if (at_one) begin
          set_tmo    = 1'b1;
          state_next = S_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (abort && state != S_IDLE) begin
      state_next = S_IDLE;
      set_abort  = 1'b1;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      set_done   = 1'b0;
      set_tmo    = 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      A_CTRL:   rd_mux[CTRL_IRQ_EN] = irq_en;
      A_RLEN:   rd_mux = 32'(rst_len);
      A_STATUS: begin
        rd_mux[STS_BUSY]    = (state != S_IDLE);
        rd_mux[STS_DONE]    = done_f;
        rd_mux[STS_TMO]     = tmo_f;
        rd_mux[STS_ABORTED] = abort_f;
        rd_mux[STS_STATE+:3] = state;
      end
      default:  rd_mux = 32'(timeout);
    endcase
  end

  // Sticky flags: a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      rst_len   <= RST_LEN_W'(RLEN_RST);
      timeout   <= '0;
      tmo_snap  <= '0;
      irq_en    <= 1'b0;
      done_f    <= 1'b0;
      tmo_f     <= 1'b0;
      abort_f   <= 1'b0;
      readdata  <= '0;
      knn_reset <= 1'b0;
      knn_start <= 1'b0;
    end else begin
      if (wr_ctrl)
        irq_en <= writedata[CTRL_IRQ_EN];
      if (wr && address == A_RLEN)
        rst_len <= writedata[RST_LEN_W-1:0];
      if (wr && address == A_TMO)
        timeout <= writedata[TMO_W-1:0];
      if (go && state == S_IDLE)
        tmo_snap <= timeout;
      done_f  <= set_done |
                 (done_f & ~(wr_status & writedata[STS_DONE]));
      tmo_f   <= set_tmo |
                 (tmo_f & ~(wr_status & writedata[STS_TMO]));
      abort_f <= set_abort |
                 (abort_f & ~(wr_status & writedata[STS_ABORTED]));
      readdata  <= rd_mux;
      knn_reset <= (state_next == S_RST);
      knn_start <= (state_next == S_START);
    end
  end

  assign irq = irq_en & (done_f | tmo_f);

endmodule

// File: tb/tb_knn_reset_sequencer.sv
// Randomized self-checking bench for knn_reset_sequencer.
// Expected timelines are computed from cycle arithmetic on the GO cycle.
module tb_knn_reset_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        knn_reset, knn_start, irq;
  logic        knn_done = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  int rst_cnt, rst_first, start_cnt, start_cyc;

  knn_reset_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .knn_reset  (knn_reset),
    .knn_start  (knn_start),
    .knn_done   (knn_done),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (knn_reset) begin
      rst_cnt++;
      if (rst_first < 0) rst_first = cyc;
    end
    if (knn_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  task automatic mon_clear();
    rst_cnt = 0;
    rst_first = -1;
    start_cnt = 0;
    start_cyc = -1;
  endtask

  task automatic trial();
    int L, M, N, T, S, E, d, done_c, spur_c, ac, clr_c, end_c;
    bit has_done, ab, ie, is_done, is_tmo;
    int exp_rst, exp_start;
    logic [31:0] v, ex;
    L  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 7);
    M  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 9);
    ie = 1'($urandom_range(0, 1));
    has_done = (M == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    d  = $urandom_range(1, (M == 0) ? 10 : M + 2);
    if (M != 0 && $urandom_range(0, 3) == 0) d = M;
    wr(2'd1, 32'(L));
    wr(2'd3, 32'(M));
    mon_clear();
    T = cyc;
    wr(2'd0, 32'h1 | (32'(ie) << 2));
    N = (L == 0) ? 1 : L;
    S = T + N + 3;
    if (has_done && (M == 0 || d <= M)) begin
      is_done = 1'b1; is_tmo = 1'b0; E = S + d;
    end else begin
      is_done = 1'b0; is_tmo = 1'b1; E = S + M;
    end
    done_c = has_done ? S + d : -100;
    spur_c = ($urandom_range(0, 1) == 1) ?
             T + 1 + $urandom_range(0, S - T - 1) : -100;
    ab = ($urandom_range(0, 3) == 0);
    ac = ab ? T + 1 + $urandom_range(0, E - T - 2) : -100;
    clr_c = (!ab && $urandom_range(0, 2) == 0) ? E : -100;
    end_c = ab ? ac : E;
    while (cyc <= end_c + 3) begin
      knn_done = (cyc == done_c) || (cyc == spur_c);
      if (cyc == ac)
        wr(2'd0, 32'h2 | (32'(ie) << 2));
      else if (cyc == clr_c)
        wr(2'd2, 32'hE);
      else
        tick();
    end
    knn_done = 1'b0;
    if (ab) begin
      exp_rst = (ac - T < N) ? ac - T : N;
      exp_start = (ac >= S) ? 1 : 0;
      is_done = 1'b0;
      is_tmo = 1'b0;
    end else begin
      exp_rst = N;
      exp_start = 1;
    end
    check("rst_len_cycles", rst_cnt, exp_rst);
    check("rst_first", rst_first, T + 1);
    check("start_count", start_cnt, exp_start);
    if (exp_start == 1)
      check("start_cycle", start_cyc, S);
    ex = (32'(ab) << 3) | (32'(is_tmo) << 2) | (32'(is_done) << 1);
    rd(2'd2, v);
    check("status", v, ex);
    check("irq", irq, ie & (is_done | is_tmo));
    wr(2'd2, 32'hE);
    rd(2'd2, v);
    check("status_clr", v, 0);
    check("irq_clr", irq, 0);
  endtask

  initial begin
    logic [31:0] v;
    int T, S;
    mon_clear();
    repeat (3) tick();
    reset = 1'b0;
    check("rst_knn_reset", knn_reset, 0);
    check("rst_knn_start", knn_start, 0);
    check("rst_irq", irq, 0);
    check("rst_readdata", readdata, 0);
    rd(2'd0, v); check("rst_ctrl", v, 0);
    rd(2'd1, v); check("rst_rlen", v, 16);
    rd(2'd2, v); check("rst_status", v, 0);
    rd(2'd3, v); check("rst_tmo", v, 0);

    mon_clear();
    wr(2'd0, 32'h3);
    repeat (4) tick();
    rd(2'd2, v); check("go_abort_idle", v, 0);
    check("go_abort_rst", rst_cnt, 0);

    for (int i = 0; i < 40; i++) trial();

    wr(2'd1, 32'd1);
    wr(2'd3, 32'd0);
    mon_clear();
    T = cyc;
    wr(2'd0, 32'h5);
    S = T + 4;
    while (cyc < S + 2) tick();
    rd(2'd2, v); check("busy_wait", v, 32'h41);
    wr(2'd0, 32'h5);
    repeat (3) tick();
    knn_done = 1'b1;
    tick();
    knn_done = 1'b0;
    tick();
    rd(2'd2, v); check("go_in_wait_sts", v, 32'h2);
    check("go_in_wait_start", start_cnt, 1);
    check("go_in_wait_rst", rst_cnt, 1);
    check("go_in_wait_irq", irq, 1);
    wr(2'd2, 32'h2);
    check("irq_after_clr", irq, 0);

    wr(2'd1, 32'd7);
    wr(2'd3, 32'd50);
    T = cyc;
    wr(2'd0, 32'h5);
    S = T + 7 + 3;
    while (cyc < S + 2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_knn_reset", knn_reset, 0);
    check("mid_rst_knn_start", knn_start, 0);
    check("mid_rst_irq", irq, 0);
    rd(2'd0, v); check("mid_rst_ctrl", v, 0);
    rd(2'd1, v); check("mid_rst_rlen", v, 16);
    rd(2'd2, v); check("mid_rst_status", v, 0);
    rd(2'd3, v); check("mid_rst_tmo", v, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
